// File: rtl/rtc_apb_poller.sv
// rtc_apb_poller: on each rtc_trig rising edge, reads the RTC data register over APB,
// writes the interrupt-clear register and presents the timestamp on a valid/ready stream.
// Optional macro RTC_POLL_TIMEOUT_EN adds a PREADY access timeout and the sticky timeout_err port.
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | bus idle; waits for a pending trigger with no unread timestamp
// S_RD_SETUP  | APB setup phase, read of DR_ADDR
// S_RD_ACCESS | APB access phase of the read; captures PRDATA on PREADY
// S_WR_SETUP  | APB setup phase, write ICR_VALUE to ICR_ADDR
// S_WR_ACCESS | APB access phase of the write; raises ts_valid on PREADY
module rtc_apb_poller #(
`ifdef RTC_POLL_TIMEOUT_EN
  parameter int TIMEOUT_CYC = 16,
`endif
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] DR_ADDR   = 12'h000,
  parameter logic [ADDR_WIDTH-1:0] ICR_ADDR  = 12'h01C,
  parameter logic [DATA_WIDTH-1:0] ICR_VALUE = 32'h1
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  rtc_trig,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  output logic [DATA_WIDTH-1:0] ts_data,
  output logic                  ts_valid,
  input  logic                  ts_ready,
  output logic                  overrun,
`ifdef RTC_POLL_TIMEOUT_EN
  output logic                  timeout_err,
`endif
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_SETUP,
    S_RD_ACCESS,
    S_WR_SETUP,
    S_WR_ACCESS
  } state_t;

  state_t                  state_q, state_d;
  logic                    trig_q;
  logic                    pending_q, pending_d;
  logic                    overrun_q, overrun_d;
  logic                    ts_valid_q, ts_valid_d;
  logic [DATA_WIDTH-1:0]   ts_data_q, ts_data_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic                    trig_edge;
  logic                    start;

`ifdef RTC_POLL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_err_q, tmo_err_d;
  logic          tmo_tc;

  // Down-counter reaches terminal count on the last allowed access cycle.
  assign tmo_tc      = (tmo_cnt_q == '0);
  assign timeout_err = tmo_err_q;
`endif

  assign trig_edge = rtc_trig & ~trig_q;

  // A new edge in the consume cycle re-arms pending rather than counting as lost.
  assign pending_d = trig_edge | (pending_q & ~start);
  assign overrun_d = overrun_q | (trig_edge & pending_q & ~start);

  always_comb begin
    state_d    = state_q;
    start      = 1'b0;
    PSEL       = 1'b0;
    PENABLE    = 1'b0;
    ts_valid_d = ts_valid_q & ~ts_ready;
    ts_data_d  = ts_data_q;
    paddr_d    = paddr_q;
    pwrite_d   = pwrite_q;
    pwdata_d   = pwdata_q;
`ifdef RTC_POLL_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
    tmo_err_d  = tmo_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pending_q && !ts_valid_q) begin
          start    = 1'b1;
          state_d  = S_RD_SETUP;
          paddr_d  = DR_ADDR;
          pwrite_d = 1'b0;
        end
      end
      S_RD_SETUP: begin
        PSEL    = 1'b1;
        state_d = S_RD_ACCESS;
`ifdef RTC_POLL_TIMEOUT_EN
        tmo_cnt_d = TMO_LOAD;
`endif
      end
      S_RD_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (PREADY) begin
          ts_data_d = PRDATA;
          state_d   = S_WR_SETUP;
          paddr_d   = ICR_ADDR;
          pwrite_d  = 1'b1;
          pwdata_d  = ICR_VALUE;
        end
`ifdef RTC_POLL_TIMEOUT_EN
        else if (tmo_tc) begin
          state_d   = S_IDLE;
          tmo_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q - TW'(1);
        end
`endif
      end
      S_WR_SETUP: begin
        PSEL    = 1'b1;
        state_d = S_WR_ACCESS;
`ifdef RTC_POLL_TIMEOUT_EN
        tmo_cnt_d = TMO_LOAD;
`endif
      end
      S_WR_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (PREADY) begin
          ts_valid_d = 1'b1;
          state_d    = S_IDLE;
        end
`ifdef RTC_POLL_TIMEOUT_EN
        else if (tmo_tc) begin
          state_d   = S_IDLE;
          tmo_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q - TW'(1);
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= S_IDLE;
      trig_q     <= 1'b0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      ts_valid_q <= 1'b0;
      ts_data_q  <= '0;
      paddr_q    <= '0;
      pwrite_q   <= 1'b0;
      pwdata_q   <= '0;
`ifdef RTC_POLL_TIMEOUT_EN
      tmo_cnt_q  <= '0;
      tmo_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      trig_q     <= rtc_trig;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      ts_valid_q <= ts_valid_d;
      ts_data_q  <= ts_data_d;
      paddr_q    <= paddr_d;
      pwrite_q   <= pwrite_d;
      pwdata_q   <= pwdata_d;
`ifdef RTC_POLL_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_err_q  <= tmo_err_d;
`endif
    end
  end

  assign PADDR    = paddr_q;
  assign PWRITE   = pwrite_q;
  assign PWDATA   = pwdata_q;
  assign ts_data  = ts_data_q;
  assign ts_valid = ts_valid_q;
  assign overrun  = overrun_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_rtc_apb_poller.sv
// Directed bench for rtc_apb_poller with a small APB slave model (programmable wait states).
module tb_rtc_apb_poller;
  localparam int AW = 12;
  localparam int DW = 32;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic          rtc_trig = 1'b0;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA = '0;
  logic          PREADY;
  logic [DW-1:0] ts_data;
  logic          ts_valid;
  logic          ts_ready = 1'b0;
  logic          overrun;
  logic          busy;
`ifdef RTC_POLL_TIMEOUT_EN
  logic          timeout_err;
`endif

  rtc_apb_poller dut (
    .PCLK(PCLK), .PRESET(PRESET), .rtc_trig(rtc_trig),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY),
    .ts_data(ts_data), .ts_valid(ts_valid), .ts_ready(ts_ready), .overrun(overrun),
`ifdef RTC_POLL_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .busy(busy)
  );

  always #5 PCLK = ~PCLK;

  // APB slave: PREADY after wait_states stalled access cycles; logs completed transfers.
  int            wait_states = 0;
  logic          stall = 1'b0;
  int            acc_cnt = 0;
  int            rd_cnt = 0, wr_cnt = 0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;

  assign PREADY = PSEL && PENABLE && !stall && (acc_cnt == wait_states);

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    if (PSEL && PENABLE && PREADY) begin
      if (PWRITE) begin
        wr_cnt  <= wr_cnt + 1;
        wr_addr <= PADDR;
        wr_data <= PWDATA;
      end else begin
        rd_cnt <= rd_cnt + 1;
      end
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic pulse_trig();
    rtc_trig = 1'b1;
    tick();
    rtc_trig = 1'b0;
    tick();
  endtask

  task automatic wait_valid(input string tag, input int bound);
    int n;
    n = 0;
    while (!ts_valid && n < bound) begin
      tick();
      n++;
    end
    chk(tag, {31'b0, ts_valid}, 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int psel_cyc, en_cyc, unstable, rd0, wr0;
    logic [AW-1:0] prev_addr;
    logic          prev_wr;

    // Reset state
    repeat (3) tick();
    chk("rst_psel", {31'b0, PSEL}, 32'h0);
    chk("rst_penable", {31'b0, PENABLE}, 32'h0);
    chk("rst_ts_valid", {31'b0, ts_valid}, 32'h0);
    chk("rst_overrun", {31'b0, overrun}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_paddr", {20'b0, PADDR}, 32'h0);
    PRESET = 1'b0;
    tick();

    // Zero-wait single transaction, cycle by cycle
    PRDATA = 32'h0000_1234;
    rtc_trig = 1'b1;
    tick();
    chk("t1_pending_no_psel", {31'b0, PSEL}, 32'h0);
    tick();
    chk("t1_rdsetup_sel_en_wr", {29'b0, PSEL, PENABLE, PWRITE}, 32'h4);
    chk("t1_rdsetup_addr", {20'b0, PADDR}, 32'h000);
    chk("t1_rdsetup_busy", {31'b0, busy}, 32'h1);
    tick();
    chk("t1_rdaccess_sel_en_wr", {29'b0, PSEL, PENABLE, PWRITE}, 32'h6);
    tick();
    chk("t1_wrsetup_sel_en_wr", {29'b0, PSEL, PENABLE, PWRITE}, 32'h5);
    chk("t1_wrsetup_addr", {20'b0, PADDR}, 32'h01C);
    chk("t1_wrsetup_wdata", PWDATA, 32'h1);
    tick();
    chk("t1_wraccess_sel_en_wr", {29'b0, PSEL, PENABLE, PWRITE}, 32'h7);
    tick();
    chk("t1_done_valid", {31'b0, ts_valid}, 32'h1);
    chk("t1_done_data", ts_data, 32'h0000_1234);
    chk("t1_done_psel_busy", {30'b0, PSEL, busy}, 32'h0);
    chk("t1_addr_held", {20'b0, PADDR}, 32'h01C);
    chk("t1_icr_write", {wr_addr, wr_data[19:0]}, {12'h01C, 20'h1});
    ts_ready = 1'b1;
    rtc_trig = 1'b0;
    tick();
    chk("t1_valid_cleared", {31'b0, ts_valid}, 32'h0);
    ts_ready = 1'b0;
    tick();

    // Three wait states per access: 10 bus cycles, stable address/control
    wait_states = 3;
    PRDATA = 32'hABCD_0001;
    rtc_trig = 1'b1;
    tick();
    rtc_trig = 1'b0;
    psel_cyc = 0; en_cyc = 0; unstable = 0;
    prev_addr = PADDR; prev_wr = PWRITE;
    for (int i = 0; i < 40 && !ts_valid; i++) begin
      tick();
      if (PSEL) psel_cyc++;
      if (PENABLE) begin
        en_cyc++;
        if (PADDR !== prev_addr || PWRITE !== prev_wr) unstable++;
      end
      prev_addr = PADDR; prev_wr = PWRITE;
    end
    chk("t2_valid", {31'b0, ts_valid}, 32'h1);
    chk("t2_psel_cycles", psel_cyc, 32'd10);
    chk("t2_penable_cycles", en_cyc, 32'd8);
    chk("t2_unstable", unstable, 32'd0);
    chk("t2_data", ts_data, 32'hABCD_0001);
    ts_ready = 1'b1;
    tick();
    ts_ready = 1'b0;
    wait_states = 0;
    tick();

    // Backpressure: second edge pends, third sets overrun
    PRDATA = 32'h1111_0001;
    pulse_trig();
    wait_valid("t3_first_valid", 20);
    chk("t3_first_data", ts_data, 32'h1111_0001);
    PRDATA = 32'h2222_0002;
    pulse_trig();
    chk("t3_no_overrun_yet", {31'b0, overrun}, 32'h0);
    psel_cyc = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (PSEL) psel_cyc++;
    end
    chk("t3_blocked_psel", psel_cyc, 32'd0);
    pulse_trig();
    chk("t3_overrun", {31'b0, overrun}, 32'h1);
    chk("t3_data_stable", ts_data, 32'h1111_0001);
    ts_ready = 1'b1;
    tick();
    ts_ready = 1'b0;
    chk("t3_valid_drop", {31'b0, ts_valid}, 32'h0);
    chk("t3_idle_gap", {31'b0, PSEL}, 32'h0);
    tick();
    chk("t3_second_start", {31'b0, PSEL}, 32'h1);
    wait_valid("t3_second_valid", 20);
    chk("t3_second_data", ts_data, 32'h2222_0002);
    ts_ready = 1'b1;
    tick();
    ts_ready = 1'b0;

    // Reset clears overrun; trig held high 100 cycles gives one transaction
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
    chk("t4_overrun_reset", {31'b0, overrun}, 32'h0);
    ts_ready = 1'b1;
    rd0 = rd_cnt; wr0 = wr_cnt;
    rtc_trig = 1'b1;
    repeat (100) tick();
    rtc_trig = 1'b0;
    repeat (5) tick();
    chk("t4_reads", rd_cnt - rd0, 32'd1);
    chk("t4_writes", wr_cnt - wr0, 32'd1);
    ts_ready = 1'b0;

    // Reset during RD_ACCESS with overrun set
    wait_states = 5;
    rd0 = rd_cnt; wr0 = wr_cnt;
    rtc_trig = 1'b1; tick();
    rtc_trig = 1'b0; tick();
    rtc_trig = 1'b1; tick();
    rtc_trig = 1'b0; tick();
    rtc_trig = 1'b1; tick();
    chk("t5_in_rd_access", {30'b0, PENABLE, PWRITE}, 32'h2);
    chk("t5_overrun_set", {31'b0, overrun}, 32'h1);
    PRESET = 1'b1;
    rtc_trig = 1'b0;
    tick();
    chk("t5_bus_released", {29'b0, PSEL, PENABLE, busy}, 32'h0);
    chk("t5_valid_overrun", {30'b0, ts_valid, overrun}, 32'h0);
    PRESET = 1'b0;
    psel_cyc = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (PSEL) psel_cyc++;
    end
    chk("t5_no_restart", psel_cyc, 32'd0);
    chk("t5_no_icr_write", wr_cnt - wr0, 32'd0);
    chk("t5_no_read", rd_cnt - rd0, 32'd0);
    wait_states = 0;

`ifdef RTC_POLL_TIMEOUT_EN
    // PREADY never asserted: released after 16 access cycles
    wr0 = wr_cnt;
    stall = 1'b1;
    chk("t6_tmo_err_init", {31'b0, timeout_err}, 32'h0);
    pulse_trig();
    en_cyc = 0;
    for (int i = 0; i < 40 && PSEL; i++) begin
      tick();
      if (PENABLE) en_cyc++;
    end
    chk("t6_access_cycles", en_cyc, 32'd16);
    chk("t6_bus_idle", {30'b0, PSEL, PENABLE}, 32'h0);
    chk("t6_timeout_err", {31'b0, timeout_err}, 32'h1);
    chk("t6_no_valid", {31'b0, ts_valid}, 32'h0);
    chk("t6_no_icr_write", wr_cnt - wr0, 32'd0);
    stall = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
